// File: rtl/dff_ser_tx.sv
// dff_ser_tx: parallel-to-serial frame transmitter.
// Accepts a WIDTH-bit word over load_valid/load_ready and shifts it out on
// txd LSB first, framed by a start bit (0) and a stop bit (1). Bit timing
// advances only on clk edges where ce=1; acceptance itself ignores ce.
// Optional macro DFF_SER_TX_PARITY_EN inserts an even-parity bit (XOR of the
// word) between the last data bit and the stop bit.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, load_ready=1, waiting for a word
// START  | driving start bit (0) until the next ce edge
// DATA   | driving shift[0]; one bit per ce edge, WIDTH bits total
// PARITY | driving even parity of the latched word (parity build only)
// STOP   | driving stop bit (1); ce edge returns to IDLE and pulses done
module dff_ser_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef DFF_SER_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             txd_nxt;
  logic             done_nxt;
`ifdef DFF_SER_TX_PARITY_EN
  logic             par, par_nxt;
`endif

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef DFF_SER_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      cnt        <= cnt_nxt;
      txd        <= txd_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      load_ready <= (state_nxt == IDLE);
`ifdef DFF_SER_TX_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

  // Next-state, next-datapath and next-output decode.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    txd_nxt   = 1'b1;
`ifdef DFF_SER_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          shift_nxt = load_data;
          cnt_nxt   = '0;
          state_nxt = START;
`ifdef DFF_SER_TX_PARITY_EN
          par_nxt   = ^load_data;
`endif
        end
      end
      START: begin
        if (ce) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (ce) begin
          shift_nxt = shift >> 1;
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef DFF_SER_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef DFF_SER_TX_PARITY_EN
      PARITY: begin
        if (ce) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (ce) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // txd is registered, so it is decoded from where the FSM is going.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
`ifdef DFF_SER_TX_PARITY_EN
      PARITY:  txd_nxt = par_nxt;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dff_ser_tx.sv
// tb_dff_ser_tx: scoreboard bench for dff_ser_tx (WIDTH=4).
// Expected line bits are queued when a word is driven and popped whenever
// the DUT starts a new bit; held bits and idle line are checked in between.
module tb_dff_ser_tx;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             ce;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             txd;
  logic             busy;
  logic             done;

  int n_chk = 0;
  int n_err = 0;
  logic sb[$];
  int frames_exp = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int ce_div = 1;
  int ce_ph = 0;
  logic rst_q = 1'b0;
  logic ce_q = 1'b0;
  logic acc_q = 1'b0;
  logic last_bit = 1'b1;

  dff_ser_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .txd        (txd),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    sb.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) sb.push_back(w[i]);
`ifdef DFF_SER_TX_PARITY_EN
    sb.push_back(^w);
`endif
    sb.push_back(1'b1);
    frames_exp++;
  endtask

  // Bit-time strobe: high on one of every ce_div cycles, changed at negedge.
  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce_ph = (ce_ph + 1) % ce_div;
      ce = (ce_ph == 0);
    end
  end

  // Edge bookkeeping for the monitor.
  always @(posedge clk) begin
    cyc++;
    rst_q = rst_n;
    ce_q  = ce;
    acc_q = rst_n && load_valid && load_ready;
    if (acc_q) acc_cyc = cyc;
  end

  // Monitor: pop a bit when a new one should start, else check it is held.
  always @(negedge clk) begin
    if (rst_q) begin
      chk_eq("ready_vs_busy", load_ready, busy === 1'b0);
      if (busy === 1'b1) begin
        if (acc_q || ce_q) begin
          chk_eq("sb_avail", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            last_bit = sb.pop_front();
            chk_eq("txd_bit", txd, last_bit);
          end
        end else begin
          chk_eq("txd_hold", txd, last_bit);
        end
      end else begin
        chk_eq("txd_idle", txd, 1'b1);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk_eq("done_busy", busy, 1'b0);
      end
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] w, input bit hold);
    int n = 0;
    load_data  = w;
    load_valid = 1'b1;
    push_frame(w);
    while (load_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("accept_to", n < 200, 1);
    @(posedge clk);
    #1;
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("idle_to", n < 1000, 1);
    #1;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'hA;

    // Reset with load_valid held high.
    repeat (2) begin
      @(negedge clk);
      chk_eq("rst_txd", txd, 1'b1);
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_done", done, 1'b0);
      chk_eq("rst_ready", load_ready, 1'b0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("ready_release", load_ready, 1'b1);
    #1 load_valid = 1'b0;

    // Basic frame, ce always high.
    send_word(4'b0110, 0);
    wait_idle();
    chk_eq("done_once", done_cnt, 1);

    // ce every third cycle.
    ce_div = 3;
    send_word(4'b1001, 0);
    wait_idle();

    // Back-to-back with load_data churning while busy.
    ce_div = 1;
    send_word(4'b1111, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done === 1'b1) break;
      #1 load_data = 4'($urandom);
      n++;
    end
    chk_eq("b2b_done_to", n < 100, 1);
    #1;
    send_word(4'b0000, 0);
    chk_eq("b2b_gap", acc_cyc - done_cyc, 1);
    wait_idle();

    // Reset during data bit 2.
    send_word(4'b1010, 0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_eq("mr_txd", txd, 1'b1);
    chk_eq("mr_busy", busy, 1'b0);
    chk_eq("mr_done", done, 1'b0);
    #1 rst_n = 1'b1;
    sb.delete();
    frames_exp--;
    send_word(4'b0101, 0);
    wait_idle();

    // Odd-count word (parity bit 1 in the parity build).
    ce_div = 2;
    send_word(4'b0111, 0);
    wait_idle();

    // A few random words at random bit rates.
    for (int k = 0; k < 6; k++) begin
      ce_div = int'($urandom_range(1, 3));
      send_word(4'($urandom), 0);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk_eq("sb_empty", sb.size(), 0);
    chk_eq("done_total", done_cnt, frames_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
